sd_spi_cmd_engine: RTL

SPI-mode SD card command engine sitting between the memory-mapped SD register block and the SD card pins. Accepts a 48-bit command frame and a start strobe from the processor side, serialises it MSB-first on MOSI in SPI mode 0, then clocks in bytes until the card's R1 response arrives or a timeout expires. Returns the response byte with a one-cycle valid pulse, plus a timeout flag.

---
 rtl/sd_spi_cmd_engine.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/sd_spi_cmd_engine.sv
// rtl/sd_spi_cmd_engine.sv - SPI-mode SD command engine: 48-bit frame out, R1 poll with NCR timeout.
// Optional power-up clock train (80 SCLK, CS high) enabled by defining SD_INIT_CLOCKS_EN.
module sd_spi_cmd_engine #(
   parameter int CLK_DIV   = 256,
   parameter int NCR_MAX   = 8,
   parameter int GAP_BYTES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [47:0] cmd,
   input  logic        start,
   output logic        busy,
   output logic        resp_valid,
   output logic [7:0]  resp,
   output logic        timeout,
   output logic        sd_sclk,
   output logic        sd_mosi,
   input  logic        sd_miso,
   output logic        sd_cs_n
);
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_SEND, S_WAIT, S_GAP, S_DONE
`ifdef SD_INIT_CLOCKS_EN
      , S_INIT
`endif
   } state_e;

`ifdef SD_INIT_CLOCKS_EN
   localparam state_e RESET_STATE = S_INIT;
   logic [6:0] init_cnt_q, init_cnt_d;
`else
   localparam state_e RESET_STATE = S_IDLE;
`endif

   state_e        state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic          sclk_q, sclk_d;
   logic          cs_n_q, cs_n_d;
   logic          busy_q, busy_d;
   logic          rv_q, rv_d;
   logic [7:0]    resp_q, resp_d;
   logic          to_q, to_d;
   logic [47:0]   tx_q, tx_d;
   logic [7:0]    rx_q, rx_d;
   logic [5:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    byte_cnt_q, byte_cnt_d;
   logic [7:0]    res_q, res_d;
   logic          res_to_q, res_to_d;
   logic          tick, rise, fall;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= RESET_STATE;
         div_q      <= '0;
         sclk_q     <= 1'b0;
         cs_n_q     <= 1'b1;
         busy_q     <= 1'b0;
         rv_q       <= 1'b0;
         resp_q     <= 8'hFF;
         to_q       <= 1'b0;
         tx_q       <= '1;
         rx_q       <= '1;
         bit_cnt_q  <= '0;
         byte_cnt_q <= '0;
         res_q      <= 8'hFF;
         res_to_q   <= 1'b0;
`ifdef SD_INIT_CLOCKS_EN
         init_cnt_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         sclk_q     <= sclk_d;
         cs_n_q     <= cs_n_d;
         busy_q     <= busy_d;
         rv_q       <= rv_d;
         resp_q     <= resp_d;
         to_q       <= to_d;
         tx_q       <= tx_d;
         rx_q       <= rx_d;
         bit_cnt_q  <= bit_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         res_q      <= res_d;
         res_to_q   <= res_to_d;
`ifdef SD_INIT_CLOCKS_EN
         init_cnt_q <= init_cnt_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      div_d      = '0;
      sclk_d     = sclk_q;
      cs_n_d     = cs_n_q;
      rv_d       = 1'b0;
      resp_d     = resp_q;
      to_d       = to_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      bit_cnt_d  = bit_cnt_q;
      byte_cnt_d = byte_cnt_q;
      res_d      = res_q;
      res_to_d   = res_to_q;
`ifdef SD_INIT_CLOCKS_EN
      init_cnt_d = init_cnt_q;
`endif
      // Divider only runs while SCLK is being generated; sclk is low on every exit.
      tick = (state_q != S_IDLE) && (state_q != S_DONE) && (div_q == DW'(CLK_DIV - 1));
      rise = tick && !sclk_q;
      fall = tick && sclk_q;
      if ((state_q != S_IDLE) && (state_q != S_DONE) && !tick)
         div_d = div_q + 1'b1;
      if (tick)
         sclk_d = ~sclk_q;
      if (rise)
         rx_d = {rx_q[6:0], sd_miso};

      case (state_q)
         S_IDLE: begin
            if (start) begin
               tx_d      = cmd;
               cs_n_d    = 1'b0;
               bit_cnt_d = '0;
               state_d   = S_SEND;
            end
         end
         S_SEND: begin
            // Shifting in ones leaves MOSI high once the last frame bit has gone out.
            if (fall) begin
               tx_d = {tx_q[46:0], 1'b1};
               if (bit_cnt_q == 6'd47) begin
                  bit_cnt_d  = '0;
                  byte_cnt_d = '0;
                  state_d    = S_WAIT;
               end else begin
                  bit_cnt_d = bit_cnt_q + 6'd1;
               end
            end
         end
         S_WAIT: begin
            if (fall) begin
               if (bit_cnt_q == 6'd7) begin
                  bit_cnt_d = '0;
                  if (!rx_q[7] || (byte_cnt_q == 8'(NCR_MAX - 1))) begin
                     res_d      = rx_q[7] ? 8'hFF : rx_q;
                     res_to_d   = rx_q[7];
                     byte_cnt_d = '0;
                     cs_n_d     = 1'b1;
                     state_d    = S_GAP;
                  end else begin
                     byte_cnt_d = byte_cnt_q + 8'd1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 6'd1;
               end
            end
         end
         S_GAP: begin
            if (fall) begin
               if (bit_cnt_q == 6'd7) begin
                  bit_cnt_d = '0;
                  if (byte_cnt_q == 8'(GAP_BYTES - 1))
                     state_d = S_DONE;
                  else
                     byte_cnt_d = byte_cnt_q + 8'd1;
               end else begin
                  bit_cnt_d = bit_cnt_q + 6'd1;
               end
            end
         end
         S_DONE: begin
            rv_d    = 1'b1;
            resp_d  = res_q;
            to_d    = res_to_q;
            state_d = S_IDLE;
         end
`ifdef SD_INIT_CLOCKS_EN
         S_INIT: begin
            if (fall) begin
               if (init_cnt_q == 7'd79)
                  state_d = S_IDLE;
               else
                  init_cnt_d = init_cnt_q + 7'd1;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   assign busy       = busy_q;
   assign resp_valid = rv_q;
   assign resp       = resp_q;
   assign timeout    = to_q;
   assign sd_sclk    = sclk_q;
   assign sd_mosi    = tx_q[47];
   assign sd_cs_n    = cs_n_q;

endmodule
